// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its surroundings (hazard unit, branch unit,
// instruction memory and the decode stage).
//   stall, redirect, redirect_pc : pipeline control into fetch
//   imem_addr / imem_data        : instruction-memory word address and read data
//   pc                           : current fetch PC
//   ifid_pc/inst/valid           : IF/ID pipeline register contents
//   fetch_count                  : instructions accepted into IF/ID since reset
// slave  = the fetch stage itself
// master = everything around it
interface fetch_stage_if #(
    parameter int ADDR_W = 12
);
    logic              stall;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       pc;
    logic [31:0]       ifid_pc;
    logic [31:0]       ifid_inst;
    logic              ifid_valid;
    logic [31:0]       fetch_count;

    modport slave (
        input  stall, redirect, redirect_pc, imem_data,
        output imem_addr, pc, ifid_pc, ifid_inst, ifid_valid, fetch_count
    );

    modport master (
        output stall, redirect, redirect_pc, imem_data,
        input  imem_addr, pc, ifid_pc, ifid_inst, ifid_valid, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Holds the word-addressed PC, presents it to instruction memory and latches
// {pc, inst, valid} into IF/ID each edge. Supports stall, redirect and a
// running fetch counter.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : fetch_stage_if.slave (control in, imem, IF/ID and status out)
// Priority per edge: reset > redirect > stall > normal.
module fetch_stage #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset,
    fetch_stage_if.slave  bus
);
    logic [31:0] pc_q;
    logic [31:0] ifid_pc_q;
    logic [31:0] ifid_inst_q;
    logic        ifid_valid_q;
    logic [31:0] fetch_count_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            ifid_pc_q     <= '0;
            ifid_inst_q   <= NOP;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= '0;
        end else if (bus.redirect) begin
            // The word read this cycle belongs to the wrong path: drop it and
            // insert a bubble. Redirect wins over stall so a taken branch is
            // never lost while the hazard unit holds the front end.
            pc_q         <= bus.redirect_pc;
            ifid_pc_q    <= '0;
            ifid_inst_q  <= NOP;
            ifid_valid_q <= 1'b0;
        end else if (!bus.stall) begin
            pc_q          <= pc_q + 32'd1;
            ifid_pc_q     <= pc_q;
            ifid_inst_q   <= bus.imem_data;
            ifid_valid_q  <= 1'b1;
            fetch_count_q <= fetch_count_q + 32'd1;
        end
        // stall: everything holds, imem_addr is unchanged so the same word is re-read
    end

    // Upper PC bits are ignored; memory aliases every 2^ADDR_W words.
    assign bus.imem_addr   = pc_q[ADDR_W-1:0];
    assign bus.pc          = pc_q;
    assign bus.ifid_pc     = ifid_pc_q;
    assign bus.ifid_inst   = ifid_inst_q;
    assign bus.ifid_valid  = ifid_valid_q;
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. Stimulus drives inputs on the falling edge
// and pushes the hand-computed state expected after the next rising edge; a
// monitor pops and compares #1 after every rising edge.
// Instruction memory model: imem_data = 32'h1000 + imem_addr.
module tb_fetch_stage;
    localparam int ADDR_W = 12;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] ifid_pc;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    logic clock;
    logic reset;
    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_stage #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(32'h0000_0000),
        .NOP     (32'h0000_0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.imem_data = 32'h1000 + {{(32-ADDR_W){1'b0}}, bus.imem_addr};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s.%s actual=%h required=%h", tag, field, act, req);
    endtask

    // monitor: compares DUT state against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, "pc",          bus.pc,          e.pc);
                chk(e.tag, "ifid_pc",     bus.ifid_pc,     e.ifid_pc);
                chk(e.tag, "ifid_inst",   bus.ifid_inst,   e.inst);
                chk(e.tag, "ifid_valid",  {31'b0, bus.ifid_valid}, {31'b0, e.valid});
                chk(e.tag, "fetch_count", bus.fetch_count, e.cnt);
                chk(e.tag, "imem_addr",   {20'b0, bus.imem_addr}, {20'b0, e.pc[ADDR_W-1:0]});
            end
        end
    end

    task automatic step(input string tag, input logic rst, input logic st, input logic rd,
                        input logic [31:0] rpc, input logic [31:0] epc, input logic [31:0] eifpc,
                        input logic [31:0] einst, input logic ev, input logic [31:0] ecnt);
        exp_t e;
        @(negedge clock);
        reset           = rst;
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        e.tag = tag; e.pc = epc; e.ifid_pc = eifpc; e.inst = einst; e.valid = ev; e.cnt = ecnt;
        sb.push_back(e);
        @(posedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset           = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // 1: reset then run        tag        rst st rd rpc            pc             ifid_pc        inst           v  cnt
        step("reset0",   0, 0, 0, 0,             32'h0,         32'h0,         32'h0,         0, 0);
        step("reset1",   0, 0, 0, 0,             32'h0,         32'h0,         32'h0,         0, 0);
        step("run1",     1, 0, 0, 0,             32'h1,         32'h0,         32'h1000,      1, 1);
        step("run2",     1, 0, 0, 0,             32'h2,         32'h1,         32'h1001,      1, 2);
        step("run3",     1, 0, 0, 0,             32'h3,         32'h2,         32'h1002,      1, 3);
        step("run4",     1, 0, 0, 0,             32'h4,         32'h3,         32'h1003,      1, 4);
        step("run5",     1, 0, 0, 0,             32'h5,         32'h4,         32'h1004,      1, 5);
        // 2: stall with pc=5
        step("stall1",   1, 1, 0, 0,             32'h5,         32'h4,         32'h1004,      1, 5);
        step("stall2",   1, 1, 0, 0,             32'h5,         32'h4,         32'h1004,      1, 5);
        step("stall3",   1, 1, 0, 0,             32'h5,         32'h4,         32'h1004,      1, 5);
        step("unstall",  1, 0, 0, 0,             32'h6,         32'h5,         32'h1005,      1, 6);
        step("run7",     1, 0, 0, 0,             32'h7,         32'h6,         32'h1006,      1, 7);
        step("run8",     1, 0, 0, 0,             32'h8,         32'h7,         32'h1007,      1, 8);
        // 3: redirect from pc=8
        step("redir",    1, 0, 1, 32'h40,        32'h40,        32'h0,         32'h0,         0, 8);
        step("redir_t",  1, 0, 0, 0,             32'h41,        32'h40,        32'h1040,      1, 9);
        // back-to-back redirects keep IF/ID a bubble
        step("b2b_a",    1, 0, 1, 32'h100,       32'h100,       32'h0,         32'h0,         0, 9);
        step("b2b_b",    1, 0, 1, 32'h200,       32'h200,       32'h0,         32'h0,         0, 9);
        step("b2b_t",    1, 0, 0, 0,             32'h201,       32'h200,       32'h1200,      1, 10);
        // redirect followed by a stalled edge delays the target
        step("rs_redir", 1, 0, 1, 32'h30,        32'h30,        32'h0,         32'h0,         0, 10);
        step("rs_stall", 1, 1, 0, 0,             32'h30,        32'h0,         32'h0,         0, 10);
        step("rs_t",     1, 0, 0, 0,             32'h31,        32'h30,        32'h1030,      1, 11);
        // 4: redirect and stall together
        step("redir_st", 1, 1, 1, 32'h20,        32'h20,        32'h0,         32'h0,         0, 11);
        // 5: wrap of pc
        step("wrap_rd",  1, 0, 1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h0,         32'h0,         0, 11);
        step("wrap1",    1, 0, 0, 0,             32'h0,         32'hFFFFFFFF,  32'h1FFF,      1, 12);
        step("wrap2",    1, 0, 0, 0,             32'h1,         32'h0,         32'h1000,      1, 13);
        // aliasing: upper PC bits ignored for addressing
        step("alias_rd", 1, 0, 1, 32'h1005,      32'h1005,      32'h0,         32'h0,         0, 13);
        step("alias",    1, 0, 0, 0,             32'h1006,      32'h1005,      32'h1005,      1, 14);
        // 6: ten fetches then reset together with redirect
        for (int k = 1; k <= 10; k++)
            step("run10", 1, 0, 0, 0, 32'h1006 + k, 32'h1005 + k, 32'h1005 + k, 1, 32'd14 + k);
        step("mid_rst",  0, 0, 1, 32'h77,        32'h0,         32'h0,         32'h0,         0, 0);
        step("post_rst", 1, 0, 0, 0,             32'h1,         32'h0,         32'h1000,      1, 1);

        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
